// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the five-stage MIPS pipeline.
// Holds the EX/MEM pipeline register, a word-addressed data memory for lw/sw
// and branch resolution from the execute-stage zero flag.
// Optional feature macro: MEM_ALIGN_CHK_EN -- when defined, stores with a
// nonzero byte offset are dropped and raise the sticky mem_fault flag.
// When undefined, offset bits are ignored and mem_fault is tied to 0.
module mem_stage #(
   parameter int DEPTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_wreg,
   input  logic        ex_m2reg,
   input  logic        ex_wmem,
   input  logic        ex_branch,
   input  logic        ex_zero,
   input  logic [31:0] ex_aluR,
   input  logic [31:0] ex_inB,
   input  logic [31:0] ex_pc,
   input  logic [4:0]  ex_destR,
   input  logic [3:0]  EXE_ins_type,
   input  logic [3:0]  EXE_ins_number,
   output logic        mem_wreg,
   output logic        mem_m2reg,
   output logic [31:0] mem_aluR,
   output logic [31:0] mem_mdata,
   output logic [4:0]  mem_destR,
   output logic        mem_pcsrc,
   output logic [31:0] mem_branch_pc,
   output logic [3:0]  MEM_ins_type,
   output logic [3:0]  MEM_ins_number,
   output logic        mem_fault
);

   localparam int AW = $clog2(DEPTH);

   logic        wreg_q,   wreg_d;
   logic        m2reg_q,  m2reg_d;
   logic        wmem_q,   wmem_d;
   logic        branch_q, branch_d;
   logic        zero_q,   zero_d;
   logic [31:0] alur_q,   alur_d;
   logic [31:0] inb_q,    inb_d;
   logic [31:0] pc_q,     pc_d;
   logic [4:0]  destr_q,  destr_d;
   logic [3:0]  type_q,   type_d;
   logic [3:0]  num_q,    num_d;
   logic        fault_q,  fault_d;

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] idx;
   logic          store_en;

   // Upper address bits are dropped, so byte addresses wrap modulo DEPTH*4.
   assign idx = alur_q[AW+1:2];

`ifdef MEM_ALIGN_CHK_EN
   assign store_en = wmem_q & (alur_q[1:0] == 2'b00);
`else
   assign store_en = wmem_q;
`endif

   // Next-state of the EX/MEM register: loads every cycle, no stall/flush.
   always_comb begin
      wreg_d   = ex_wreg;
      m2reg_d  = ex_m2reg;
      wmem_d   = ex_wmem;
      branch_d = ex_branch;
      zero_d   = ex_zero;
      alur_d   = ex_aluR;
      inb_d    = ex_inB;
      pc_d     = ex_pc;
      destr_d  = ex_destR;
      type_d   = EXE_ins_type;
      num_d    = EXE_ins_number;
`ifdef MEM_ALIGN_CHK_EN
      fault_d  = fault_q | (wmem_q & (alur_q[1:0] != 2'b00));
`else
      fault_d  = 1'b0;
`endif
   end

   // EX/MEM pipeline register with synchronous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wreg_q   <= 1'b0;
         m2reg_q  <= 1'b0;
         wmem_q   <= 1'b0;
         branch_q <= 1'b0;
         zero_q   <= 1'b0;
         alur_q   <= '0;
         inb_q    <= '0;
         pc_q     <= '0;
         destr_q  <= '0;
         type_q   <= '0;
         num_q    <= '0;
         fault_q  <= 1'b0;
      end else begin
         wreg_q   <= wreg_d;
         m2reg_q  <= m2reg_d;
         wmem_q   <= wmem_d;
         branch_q <= branch_d;
         zero_q   <= zero_d;
         alur_q   <= alur_d;
         inb_q    <= inb_d;
         pc_q     <= pc_d;
         destr_q  <= destr_d;
         type_q   <= type_d;
         num_q    <= num_d;
         fault_q  <= fault_d;
      end
   end

   // Data memory write at the end of the store's MEM cycle; reset blocks it.
   always_ff @(posedge clk) begin
      if (rst_n && store_en) begin
         mem_q[idx] <= inb_q;
      end
   end

   assign mem_mdata      = mem_q[idx];
   assign mem_wreg       = wreg_q;
   assign mem_m2reg      = m2reg_q;
   assign mem_aluR       = alur_q;
   assign mem_destR      = destr_q;
   assign mem_pcsrc      = branch_q & zero_q;
   assign mem_branch_pc  = pc_q;
   assign MEM_ins_type   = type_q;
   assign MEM_ins_number = num_q;
   assign mem_fault      = fault_q;

endmodule
